// File: rtl/aes_key_expander_if.sv
// aes_key_expander_if
//   Bundles the control and round-key read signals of the AES key expander.
//   master : cipher-core side (drives start/key and read requests)
//   slave  : key expander side (returns status and round keys)
//   Signals: start, key_len[1:0], key_in[MAX_KEY_BITS-1:0], busy, done,
//            rk_valid, err, rk_rd_en, rk_rd_idx[3:0], rk_rd_data[127:0]
interface aes_key_expander_if #(
  parameter int MAX_KEY_BITS = 256
);
  logic                    start;
  logic [1:0]              key_len;
  logic [MAX_KEY_BITS-1:0] key_in;
  logic                    busy;
  logic                    done;
  logic                    rk_valid;
  logic                    err;
  logic                    rk_rd_en;
  logic [3:0]              rk_rd_idx;
  logic [127:0]            rk_rd_data;

  modport master (
    output start, key_len, key_in, rk_rd_en, rk_rd_idx,
    input  busy, done, rk_valid, err, rk_rd_data
  );

  modport slave (
    input  start, key_len, key_in, rk_rd_en, rk_rd_idx,
    output busy, done, rk_valid, err, rk_rd_data
  );
endinterface

// File: rtl/aes_key_expander.sv
// sbox
//   AES forward S-box, computed as GF(2^8) inverse followed by the affine map.
//   in_byte  : input byte
//   out_byte : substituted byte
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  always_comb begin
    logic [7:0] p;
    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires
    inv = 8'h01;
    p   = in_byte;
    for (int unsigned k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// aes_key_expander
//   Sequential AES-128/192/256 key schedule, one 32-bit word per clock, with
//   an internal round-key store and a registered 128-bit read port.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of aes_key_expander_if (start/key_len/key_in in,
//           busy/done/rk_valid/err out, rk_rd_en/rk_rd_idx in, rk_rd_data out)
module aes_key_expander #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_key_expander_if.slave    bus
);
  localparam int MAX_NK = MAX_KEY_BITS / 32;
  localparam int DEPTH  = (MAX_KEY_BITS >= 256) ? 60 : (MAX_KEY_BITS >= 192) ? 52 : 44;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GEN  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [1:0]   len_q, len_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   mod_q, mod_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   nr_q, nr_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         rk_valid_q, rk_valid_d;
  logic         err_q, err_d;
  logic [127:0] rd_data_q, rd_data_d;
  logic [31:0]  win_q [8];
  logic [31:0]  win_d [8];
  logic [31:0]  store_q [DEPTH];
  logic [31:0]  store_d [DEPTH];

  // Parameters of the running expansion
  logic [2:0]   nk_m1;
  logic [5:0]   last_idx;
  logic [31:0]  w_old;

  always_comb begin
    case (len_q)
      2'd0:    begin nk_m1 = 3'd3; last_idx = 6'd43; w_old = win_q[3]; end
      2'd1:    begin nk_m1 = 3'd5; last_idx = 6'd51; w_old = win_q[5]; end
      default: begin nk_m1 = 3'd7; last_idx = 6'd59; w_old = win_q[7]; end
    endcase
  end

  // Legality of an incoming start
  logic        len_ok;
  int unsigned nk_new;

  always_comb begin
    case (bus.key_len)
      2'd0:    len_ok = 1'b1;
      2'd1:    len_ok = (MAX_KEY_BITS >= 192);
      2'd2:    len_ok = (MAX_KEY_BITS >= 256);
      default: len_ok = 1'b0;
    endcase
    nk_new = 4 + 2 * int'(bus.key_len);
  end

  // SubWord datapath: one set of four S-boxes serves both the RotWord and
  // the plain SubWord (AES-256, i mod 8 == 4) cases.
  logic [31:0] sb_in, sb_out, temp, new_word;

  assign sb_in = (mod_q == 3'd0) ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (
      .in_byte  (sb_in[8*g +: 8]),
      .out_byte (sb_out[8*g +: 8])
    );
  end

  always_comb begin
    if (mod_q == 3'd0)                      temp = sb_out ^ {rcon_q, 24'h0};
    else if (len_q == 2'd2 && mod_q == 3'd4) temp = sb_out;
    else                                     temp = win_q[0];
    new_word = w_old ^ temp;
  end

  // Next-state logic; win_q[k] holds w[i-1-k]
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    i_d        = i_q;
    mod_d      = mod_q;
    rcon_d     = rcon_q;
    nr_d       = nr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rk_valid_d = rk_valid_q;
    err_d      = 1'b0;
    win_d      = win_q;
    store_d    = store_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            state_d    = GEN;
            len_d      = bus.key_len;
            i_d        = 6'(nk_new);
            mod_d      = '0;
            rcon_d     = 8'h01;
            nr_d       = 4'(nk_new + 6);
            busy_d     = 1'b1;
            rk_valid_d = 1'b0;
            for (int unsigned j = 0; j < MAX_NK; j++) begin
              if (j < nk_new) begin
                store_d[6'(j)]            = bus.key_in[MAX_KEY_BITS-1-32*j -: 32];
                win_d[3'(nk_new - 1 - j)] = bus.key_in[MAX_KEY_BITS-1-32*j -: 32];
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        store_d[i_q] = new_word;
        for (int unsigned j = 7; j > 0; j--) win_d[j] = win_q[j-1];
        win_d[0] = new_word;
        i_d      = i_q + 6'd1;
        mod_d    = (mod_q == nk_m1) ? 3'd0 : mod_q + 3'd1;
        if (mod_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (i_q == last_idx) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          rk_valid_d = 1'b1;
        end
      end
    endcase
  end

  // Registered read port
  logic [5:0] rd_base;
  assign rd_base = {bus.rk_rd_idx, 2'b00};

  always_comb begin
    rd_data_d = rd_data_q;
    if (bus.rk_rd_en) begin
      if (rk_valid_q && bus.rk_rd_idx <= nr_q)
        rd_data_d = {store_q[rd_base], store_q[rd_base + 6'd1],
                     store_q[rd_base + 6'd2], store_q[rd_base + 6'd3]};
      else
        rd_data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      i_q        <= '0;
      mod_q      <= '0;
      rcon_q     <= 8'h01;
      nr_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      for (int unsigned j = 0; j < 8; j++) win_q[j] <= '0;
      for (int unsigned j = 0; j < DEPTH; j++) store_q[j] <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      i_q        <= i_d;
      mod_q      <= mod_d;
      rcon_q     <= rcon_d;
      nr_q       <= nr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rk_valid_q <= rk_valid_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      win_q      <= win_d;
      store_q    <= store_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rk_valid   = rk_valid_q;
  assign bus.err        = err_q;
  assign bus.rk_rd_data = rd_data_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander
//   Self-checking bench: a 256-bit build exercises all key sizes, rejection,
//   reset and back-to-back expansion; a 128-bit build checks size rejection.
//   Read results are checked through an expected-value queue.
module tb_aes_key_expander;
  logic clk;
  logic rst_n;

  aes_key_expander_if #(.MAX_KEY_BITS(256)) bus1 ();
  aes_key_expander_if #(.MAX_KEY_BITS(128)) bus2 ();

  aes_key_expander #(.MAX_KEY_BITS(256)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  aes_key_expander #(.MAX_KEY_BITS(128)) u_dut128 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q [$];
  string        tag_q [$];
  logic         rd_pend;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Read scoreboard: a strobe seen at a rising edge is compared on the next falling edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= bus1.rk_rd_en;
  end

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) check("rd_unexpected", 128'd1, 128'd0);
      else check(tag_q.pop_front(), bus1.rk_rd_data, exp_q.pop_front());
    end
  end

  // All tasks are entered and left just after a falling edge
  task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string tag);
    bus1.rk_rd_en  = 1'b1;
    bus1.rk_rd_idx = idx;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    bus1.rk_rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_expand(input logic [1:0] len, input logic [255:0] key,
                            input int exp_cyc, input bit rd_busy, input string tag);
    int n;
    bus1.start   = 1'b1;
    bus1.key_len = len;
    bus1.key_in  = key;
    @(negedge clk);
    bus1.start = 1'b0;
    check({tag, "_busy"}, 128'(bus1.busy), 128'd1);
    check({tag, "_valid_clr"}, 128'(bus1.rk_valid), 128'd0);
    n = 0;
    while (!bus1.done && n < 200) begin
      @(negedge clk);
      n++;
      if (rd_busy && n == 10) begin
        bus1.rk_rd_en  = 1'b1;
        bus1.rk_rd_idx = 4'd0;
        exp_q.push_back(128'd0);
        tag_q.push_back({tag, "_rd_busy"});
      end
      if (n == 11) bus1.rk_rd_en = 1'b0;
    end
    check({tag, "_cycles"}, 128'(n), 128'(exp_cyc));
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 128'(bus1.done), 128'd0);
    check({tag, "_busy_off"}, 128'(bus1.busy), 128'd0);
    check({tag, "_valid"}, 128'(bus1.rk_valid), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n          = 1'b0;
    bus1.start     = 1'b0;
    bus1.key_len   = '0;
    bus1.key_in    = '0;
    bus1.rk_rd_en  = 1'b0;
    bus1.rk_rd_idx = '0;
    bus2.start     = 1'b0;
    bus2.key_len   = '0;
    bus2.key_in    = '0;
    bus2.rk_rd_en  = 1'b0;
    bus2.rk_rd_idx = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(bus1.busy), 128'd0);
    check("rst_done", 128'(bus1.done), 128'd0);
    check("rst_valid", 128'(bus1.rk_valid), 128'd0);
    check("rst_err", 128'(bus1.err), 128'd0);
    check("rst_data", bus1.rk_rd_data, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // AES-128
    run_expand(2'd0, {K128, 128'h0}, 40, 1'b0, "a128");
    after_done("a128");
    rd(4'd1, R1_128, "a128_rk1");
    rd(4'd10, R10_128, "a128_rk10");
    rd(4'd11, 128'd0, "a128_rk11");
    rd(4'd0, K128, "a128_rk0");
    repeat (3) @(negedge clk);
    check("rd_hold", bus1.rk_rd_data, K128);

    // Illegal key_len leaves the schedule intact
    bus1.start   = 1'b1;
    bus1.key_len = 2'd3;
    @(negedge clk);
    bus1.start = 1'b0;
    check("ill_err", 128'(bus1.err), 128'd1);
    check("ill_busy", 128'(bus1.busy), 128'd0);
    check("ill_valid", 128'(bus1.rk_valid), 128'd1);
    @(negedge clk);
    check("ill_err_pulse", 128'(bus1.err), 128'd0);
    rd(4'd10, R10_128, "ill_rk10");

    // AES-192
    run_expand(2'd1, {K192, 64'h0}, 46, 1'b0, "a192");
    after_done("a192");
    rd(4'd12, R12_192, "a192_rk12");
    rd(4'd13, 128'd0, "a192_rk13");

    // AES-256 with a read while busy
    run_expand(2'd2, K256, 52, 1'b1, "a256");
    after_done("a256");
    rd(4'd14, R14_256, "a256_rk14");

    // Back-to-back: second start in the cycle after done
    run_expand(2'd1, {K192, 64'h0}, 46, 1'b0, "b2b_a");
    run_expand(2'd0, {K128, 128'h0}, 40, 1'b0, "b2b_b");
    after_done("b2b_b");
    rd(4'd10, R10_128, "b2b_rk10");

    // Mid-expansion start ignored, then reset at cycle 20 of AES-256
    bus1.start   = 1'b1;
    bus1.key_len = 2'd2;
    bus1.key_in  = K256;
    @(negedge clk);
    bus1.start = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 5) begin
        bus1.start   = 1'b1;
        bus1.key_len = 2'd0;
      end
      if (n == 6) begin
        bus1.start = 1'b0;
        check("mid_err", 128'(bus1.err), 128'd0);
        check("mid_busy", 128'(bus1.busy), 128'd1);
      end
      if (n == 19) check("mid_still_busy", 128'(bus1.busy), 128'd1);
    end
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 128'(bus1.busy), 128'd0);
    check("mrst_done", 128'(bus1.done), 128'd0);
    check("mrst_valid", 128'(bus1.rk_valid), 128'd0);
    check("mrst_err", 128'(bus1.err), 128'd0);
    check("mrst_data", bus1.rk_rd_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_valid2", 128'(bus1.rk_valid), 128'd0);
    rd(4'd0, 128'd0, "mrst_rk0");
    run_expand(2'd0, {K128, 128'h0}, 40, 1'b0, "fresh");
    after_done("fresh");
    rd(4'd10, R10_128, "fresh_rk10");
    rd(4'd1, R1_128, "fresh_rk1");

    // 128-bit build: AES-128 then a rejected AES-256 request
    bus2.start   = 1'b1;
    bus2.key_len = 2'd0;
    bus2.key_in  = K128;
    @(negedge clk);
    bus2.start = 1'b0;
    n = 0;
    while (!bus2.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("m128_cycles", 128'(n), 128'd40);
    bus2.rk_rd_en  = 1'b1;
    bus2.rk_rd_idx = 4'd10;
    @(negedge clk);
    bus2.rk_rd_en = 1'b0;
    check("m128_rk10", bus2.rk_rd_data, R10_128);
    bus2.start   = 1'b1;
    bus2.key_len = 2'd2;
    @(negedge clk);
    bus2.start = 1'b0;
    check("m128_err", 128'(bus2.err), 128'd1);
    check("m128_busy", 128'(bus2.busy), 128'd0);
    @(negedge clk);
    check("m128_err_pulse", 128'(bus2.err), 128'd0);
    check("m128_busy2", 128'(bus2.busy), 128'd0);
    bus2.rk_rd_en  = 1'b1;
    bus2.rk_rd_idx = 4'd10;
    @(negedge clk);
    bus2.rk_rd_en = 1'b0;
    check("m128_rk10_kept", bus2.rk_rd_data, R10_128);

    @(negedge clk);
    check("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
